// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
//
// Central stall/flush sequencer for the 5-stage pipeline. It drives the load
// enables and NOP-insert controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB
// registers. It resolves load-use hazards, taken-branch squashes, multi-cycle
// instruction/data memory waits and halt. A watchdog raises a sticky error
// when a memory wait never completes.
//
// Optional feature macro: PIPE_CTRL_PERF_EN
//   When defined, perf_stall and perf_flush are saturating event counters.
//   When undefined, both outputs are tied to zero and no counter logic exists.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   id_rs, id_rt              source registers of the instruction in ID
//   id_uses_rs, id_uses_rt    ID instruction really reads rs / rt
//   ex_rd                     destination register of the instruction in EX
//   ex_memread, ex_regwrite   EX instruction is a load / writes the reg file
//   br_taken                  branch/jump resolved taken in EX
//   imem_stall, imem_done     instruction memory busy / data valid
//   dmem_stall, dmem_done     data memory busy / data valid
//   halt_wb                   HALT instruction in WB
//   pc_en                     PC load enable
//   ifid_en, ifid_flush       IF/ID enable / NOP insert
//   idex_en, idex_flush       ID/EX enable / NOP insert
//   exmem_en                  EX/MEM enable
//   memwb_flush               NOP insert into MEM/WB
//   halted                    pipeline halted
//   err                       sticky memory-wait watchdog error
//   perf_stall, perf_flush    performance counters
// ---------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int REG_W    = 3,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memread,
  input  logic             ex_regwrite,
  input  logic             br_taken,
  input  logic             imem_stall,
  input  logic             imem_done,
  input  logic             dmem_stall,
  input  logic             dmem_done,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_flush,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] perf_stall,
  output logic [CNT_W-1:0] perf_flush
);

  typedef enum logic [1:0] {RUN, DWAIT, IWAIT, HALT} state_t;

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_WAIT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;
  logic             lduse;
  logic             waiting_q, waiting_d;

  // A load in EX whose result is needed by the instruction in ID.
  assign lduse = ex_memread & ex_regwrite &
                 ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

  // Next-state and output decode. Outputs start at the free-running pipe
  // values and each event only overrides what it has to; within a state the
  // if/else chain encodes the event priority.
  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    memwb_flush = 1'b0;
    case (state_q)
      RUN: begin
        if (halt_wb) begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          state_d  = HALT;
        end else if (dmem_stall) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_en    = 1'b0;
          memwb_flush = 1'b1;
          state_d     = DWAIT;
        end else if (br_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (lduse) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end else if (imem_stall) begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
          state_d    = IWAIT;
        end
      end
      DWAIT: begin
        // Whole pipe frozen; only completion of the data access matters.
        if (dmem_done) begin
          state_d = RUN;
        end else begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_en    = 1'b0;
          memwb_flush = 1'b1;
        end
      end
      IWAIT: begin
        if (halt_wb) begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          state_d  = HALT;
        end else if (dmem_stall) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_en    = 1'b0;
          memwb_flush = 1'b1;
          state_d     = DWAIT;
        end else if (br_taken) begin
          // Pending fetch is abandoned; PC loads the branch target.
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          state_d    = RUN;
        end else if (imem_done) begin
          state_d = RUN;
        end else begin
          // Fetch still outstanding: bubbles into ID, back end keeps going,
          // and a load-use hazard additionally holds ID and bubbles EX.
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
          if (lduse) begin
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end
        end
      end
      HALT: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
      end
      default: state_d = RUN;
    endcase
  end

  assign halted = (state_q == HALT);
  assign err    = err_q;

  // Watchdog: the count restarts whenever a wait state is entered (including
  // IWAIT -> DWAIT) and saturates at the limit; err latches at the edge where
  // the count reaches the limit.
  assign waiting_q = (state_q == DWAIT) || (state_q == IWAIT);
  assign waiting_d = (state_d == DWAIT) || (state_d == IWAIT);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (waiting_d && (state_d != state_q)) begin
      wait_cnt_d = '0;
    end else if (waiting_q && (wait_cnt_q != MaxCnt)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    err_d = err_q | (waiting_q && (wait_cnt_d == MaxCnt));
  end

  // State, watchdog count and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] perf_stall_q, perf_flush_q;
  logic             stallEvt, flushEvt;

  // A stall cycle is any cycle the PC is held outside of HALT; a flush event
  // is a taken branch that actually wins priority and squashes IF/ID and ID/EX.
  assign stallEvt = ~pc_en & (state_q != HALT);
  assign flushEvt = br_taken & ~halt_wb & ~dmem_stall &
                    ((state_q == RUN) || (state_q == IWAIT));

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stallEvt && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 1'b1;
      if (flushEvt && (perf_flush_q != '1)) perf_flush_q <= perf_flush_q + 1'b1;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
//
// Directed self-checking bench for pipe_ctrl (MAX_WAIT = 8). Control outputs
// are packed into one vector {pc_en, ifid_en, ifid_flush, idex_en,
// idex_flush, exmem_en, memwb_flush, halted} and compared against
// hand-derived constants. Expected performance counts are accumulated from
// the expected vectors, so they only matter when PIPE_CTRL_PERF_EN is set.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int REG_W    = 3;
  localparam int CNT_W    = 16;
  localparam int MAX_WAIT = 8;

  // Expected control vectors
  localparam logic [7:0] VecRun    = 8'b1101_0100;
  localparam logic [7:0] VecLduse  = 8'b0001_1100;
  localparam logic [7:0] VecBranch = 8'b1111_1100;
  localparam logic [7:0] VecDwait  = 8'b0000_0010;
  localparam logic [7:0] VecIwait  = 8'b0111_0100;
  localparam logic [7:0] VecIwLd   = 8'b0011_1100;
  localparam logic [7:0] VecHaltGo = 8'b0000_0000;
  localparam logic [7:0] VecHalted = 8'b0000_0001;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] id_rs, id_rt, ex_rd;
  logic             id_uses_rs, id_uses_rt, ex_memread, ex_regwrite;
  logic             br_taken, imem_stall, imem_done, dmem_stall, dmem_done, halt_wb;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic             exmem_en, memwb_flush, halted, err;
  logic [CNT_W-1:0] perf_stall, perf_flush;

  int assertCount = 0;
  int failCount   = 0;
  int expStall    = 0;
  int expFlush    = 0;

  pipe_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
    .br_taken(br_taken), .imem_stall(imem_stall), .imem_done(imem_done),
    .dmem_stall(dmem_stall), .dmem_done(dmem_done), .halt_wb(halt_wb),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .memwb_flush(memwb_flush), .halted(halted), .err(err),
    .perf_stall(perf_stall), .perf_flush(perf_flush)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Return all inputs to a quiet pipe
  task automatic applyStimulus();
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_uses_rs = 0; id_uses_rt = 0; ex_memread = 0; ex_regwrite = 0;
    br_taken = 0; imem_stall = 0; imem_done = 0;
    dmem_stall = 0; dmem_done = 0; halt_wb = 0;
  endtask

  // Settle, check the control vector, account the expected perf events,
  // then advance to just after the next rising edge
  task automatic runCycle(input string tag, input logic [7:0] expVec, input bit brFlush);
    #2;
    checkOutput(tag, {24'd0, pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                      exmem_en, memwb_flush, halted}, {24'd0, expVec});
    if (!expVec[7] && !expVec[0]) expStall++;
    if (brFlush) expFlush++;
    @(posedge clk); #1;
  endtask

  task automatic pulseReset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    expStall = 0;
    expFlush = 0;
  endtask

  task automatic checkPerf(input string tag);
    #2;
`ifdef PIPE_CTRL_PERF_EN
    checkOutput({tag, "_pstall"}, 32'(perf_stall), 32'(expStall));
    checkOutput({tag, "_pflush"}, 32'(perf_flush), 32'(expFlush));
`else
    checkOutput({tag, "_pstall"}, 32'(perf_stall), 32'd0);
    checkOutput({tag, "_pflush"}, 32'(perf_flush), 32'd0);
`endif
  endtask

  initial begin
    applyStimulus();
    rst = 1;
    @(posedge clk); @(posedge clk); #1;
    pulseReset();

    // Reset state
    #1;
    checkOutput("rst_err", 32'(err), 32'd0);
    checkPerf("rst");
    runCycle("rst_run", VecRun, 0);

    // Load-use on rs, then load gone
    ex_memread = 1; ex_regwrite = 1; ex_rd = 3; id_rs = 3; id_uses_rs = 1;
    runCycle("lduse_rs", VecLduse, 0);
    applyStimulus();
    runCycle("lduse_after", VecRun, 0);
    // Load-use on rt
    ex_memread = 1; ex_regwrite = 1; ex_rd = 5; id_rt = 5; id_uses_rt = 1; id_rs = 5;
    runCycle("lduse_rt", VecLduse, 0);
    // Matching register but not actually read: no hazard
    id_uses_rt = 0;
    runCycle("lduse_unused", VecRun, 0);
    // Load that does not write the register file: no hazard
    id_uses_rt = 1; ex_regwrite = 0;
    runCycle("lduse_nowr", VecRun, 0);
    // Register mismatch: no hazard
    ex_regwrite = 1; ex_rd = 4;
    runCycle("lduse_miss", VecRun, 0);

    // Branch together with load-use: branch wins
    ex_rd = 5;
    br_taken = 1;
    runCycle("br_lduse", VecBranch, 1);
    applyStimulus();
    checkPerf("br");
    runCycle("br_after", VecRun, 0);

    // Data-memory wait: 4 stalled cycles, branch ignored while frozen
    dmem_stall = 1;
    runCycle("dw_enter", VecDwait, 0);
    runCycle("dw_1", VecDwait, 0);
    br_taken = 1;
    runCycle("dw_br_ign", VecDwait, 0);
    br_taken = 0; imem_stall = 1;
    runCycle("dw_3", VecDwait, 0);
    applyStimulus();
    dmem_done = 1;
    runCycle("dw_done", VecRun, 0);
    applyStimulus();
    runCycle("dw_after", VecRun, 0);
    checkOutput("dw_err", 32'(err), 32'd0);

    // Instruction-memory wait aborted by a branch, with load-use in IWAIT
    imem_stall = 1;
    runCycle("iw_enter", VecIwait, 0);
    imem_stall = 0;
    runCycle("iw_1", VecIwait, 0);
    ex_memread = 1; ex_regwrite = 1; ex_rd = 2; id_rs = 2; id_uses_rs = 1;
    runCycle("iw_lduse", VecIwLd, 0);
    applyStimulus();
    br_taken = 1;
    runCycle("iw_br", VecBranch, 1);
    applyStimulus();
    runCycle("iw_br_run", VecRun, 0);

    // Instruction-memory wait completed normally
    imem_stall = 1;
    runCycle("iw2_enter", VecIwait, 0);
    imem_stall = 0; imem_done = 1;
    runCycle("iw2_done", VecRun, 0);
    applyStimulus();
    runCycle("iw2_run", VecRun, 0);
    checkPerf("iw");

    // Watchdog: err rises after 8 DWAIT cycles and sticks
    dmem_stall = 1;
    for (int s = 1; s <= 20; s++) begin
      #1;
      checkOutput($sformatf("wd_err_%0d", s), 32'(err), (s >= 10) ? 32'd1 : 32'd0);
      #(-1 + 1);
      runCycle($sformatf("wd_vec_%0d", s), VecDwait, 0);
    end
    applyStimulus();
    dmem_done = 1;
    runCycle("wd_done", VecRun, 0);
    applyStimulus();
    runCycle("wd_run", VecRun, 0);
    checkOutput("wd_sticky", 32'(err), 32'd1);
    checkPerf("wd");
    pulseReset();
    #1;
    checkOutput("wd_rst_err", 32'(err), 32'd0);
    runCycle("wd_rst_run", VecRun, 0);

    // Halt, frozen under random inputs, then reset back to RUN
    halt_wb = 1;
    runCycle("halt_go", VecHaltGo, 0);
    for (int i = 0; i < 10; i++) begin
      id_rs = REG_W'($urandom); id_rt = REG_W'($urandom); ex_rd = REG_W'($urandom);
      id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
      ex_memread = 1'($urandom); ex_regwrite = 1'($urandom);
      br_taken = 1'($urandom); imem_stall = 1'($urandom); imem_done = 1'($urandom);
      dmem_stall = 1'($urandom); dmem_done = 1'($urandom); halt_wb = 1'($urandom);
      runCycle($sformatf("halt_%0d", i), VecHalted, 0);
    end
    checkPerf("halt");
    applyStimulus();
    pulseReset();
    runCycle("halt_rst_run", VecRun, 0);
    checkOutput("halt_rst_err", 32'(err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
